// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: memory-handshake state
// encoding and register-address constants.
package pipeline_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds a
// source operand of the instruction in ID. Writes to x0 never create a hazard.
module pipeline_stall_ctrl_hazard_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  load_use
);

  assign load_use = ex_mem_read & (ex_rd_addr != REG_X0) &
                    ((ex_rd_addr == rs1_addr) | (ex_rd_addr == rs2_addr));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Backward-flowing pipeline control: load-use bubbles, branch flushes, a
// data-memory handshake that freezes the pipe on a miss, plus stall statistics.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] IFID_RS1addr_i,
  input  logic [REG_ADDR_W-1:0] IFID_RS2addr_i,
  input  logic                  IDEX_MemRead_i,
  input  logic [REG_ADDR_W-1:0] IDEX_RDaddr_i,
  input  logic                  Branch_taken_i,
  input  logic                  EXMEM_MemRead_i,
  input  logic                  EXMEM_MemWrite_i,
  input  logic                  mem_ack_i,
  output logic                  mem_req_o,
  output logic                  PC_write_o,
  output logic                  IFID_write_o,
  output logic                  IFID_flush_o,
  output logic                  IDEX_flush_o,
  output logic                  pipe_freeze_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic                  timeout_err_o
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              access;
  logic              load_use;
  logic              wait_expired;
  logic              mem_stall;

  pipeline_stall_ctrl_hazard_detect u_hazard_detect (
    .rs1_addr    (IFID_RS1addr_i),
    .rs2_addr    (IFID_RS2addr_i),
    .ex_mem_read (IDEX_MemRead_i),
    .ex_rd_addr  (IDEX_RDaddr_i),
    .load_use    (load_use)
  );

  assign access       = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign wait_expired = (state == MEM_WAIT) & (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign mem_req_o    = (state == MEM_WAIT) | access;
  // The final timed-out wait cycle behaves like an ack so the pipe can move on.
  assign mem_stall    = mem_req_o & ~mem_ack_i & ~wait_expired;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access & ~mem_ack_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (mem_ack_i) begin
            state <= IDLE;
          end else if (wait_expired) begin
            state         <= IDLE;
            timeout_err_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A memory freeze masks hazard/branch requests; they re-evaluate once released.
  always_comb begin
    pipe_freeze_o = 1'b0;
    PC_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IFID_flush_o  = 1'b0;
    IDEX_flush_o  = 1'b0;
    if (mem_stall) begin
      pipe_freeze_o = 1'b1;
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
    end else if (load_use) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_flush_o  = 1'b1;
    end else if (Branch_taken_i) begin
      IFID_flush_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
    end else if (mem_stall | load_use) begin
      stall_cycles_o <= stall_cycles_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios then random
// traffic, all compared against a cycle-age based reference model.
module tb_pipeline_stall_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [4:0]       IFID_RS1addr_i, IFID_RS2addr_i, IDEX_RDaddr_i;
  logic             IDEX_MemRead_i, Branch_taken_i;
  logic             EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i;
  logic             mem_req_o, PC_write_o, IFID_write_o, IFID_flush_o;
  logic             IDEX_flush_o, pipe_freeze_o, timeout_err_o;
  logic [CNT_W-1:0] stall_cycles_o;

  int errors = 0;
  int checks = 0;

  // Reference model: age of the outstanding access in cycles (-1 = none).
  int age       = -1;
  int stallsRef = 0;
  bit errRef    = 1'b0;

  pipeline_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .IFID_RS1addr_i   (IFID_RS1addr_i),
    .IFID_RS2addr_i   (IFID_RS2addr_i),
    .IDEX_MemRead_i   (IDEX_MemRead_i),
    .IDEX_RDaddr_i    (IDEX_RDaddr_i),
    .Branch_taken_i   (Branch_taken_i),
    .EXMEM_MemRead_i  (EXMEM_MemRead_i),
    .EXMEM_MemWrite_i (EXMEM_MemWrite_i),
    .mem_ack_i        (mem_ack_i),
    .mem_req_o        (mem_req_o),
    .PC_write_o       (PC_write_o),
    .IFID_write_o     (IFID_write_o),
    .IFID_flush_o     (IFID_flush_o),
    .IDEX_flush_o     (IDEX_flush_o),
    .pipe_freeze_o    (pipe_freeze_o),
    .stall_cycles_o   (stall_cycles_o),
    .timeout_err_o    (timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input bit ld, input bit br, input bit rdM, input bit wrM, input bit ack);
    bit acc, lu, req, timedOut, stall;
    int curAge;
    @(negedge clk_i);
    IFID_RS1addr_i   = rs1;
    IFID_RS2addr_i   = rs2;
    IDEX_RDaddr_i    = rd;
    IDEX_MemRead_i   = ld;
    Branch_taken_i   = br;
    EXMEM_MemRead_i  = rdM;
    EXMEM_MemWrite_i = wrM;
    mem_ack_i        = ack;
    #1;
    acc      = rdM || wrM;
    lu       = ld && (rd != 0) && (rd == rs1 || rd == rs2);
    curAge   = (age >= 0) ? age : 0;
    req      = (age >= 0) || acc;
    timedOut = (age == TIMEOUT) && !ack;
    stall    = req && !ack && !timedOut;
    checkOutput("mem_req", 32'(mem_req_o), 32'(req));
    checkOutput("pipe_freeze", 32'(pipe_freeze_o), 32'(stall));
    checkOutput("pc_write", 32'(PC_write_o), 32'(!stall && !lu));
    checkOutput("ifid_write", 32'(IFID_write_o), 32'(!stall && !lu));
    checkOutput("idex_flush", 32'(IDEX_flush_o), 32'(!stall && lu));
    checkOutput("ifid_flush", 32'(IFID_flush_o), 32'(!stall && !lu && br));
    @(posedge clk_i);
    #1;
    age = stall ? curAge + 1 : -1;
    if (timedOut) errRef = 1'b1;
    if (stall || lu) stallsRef++;
    checkOutput("stall_cycles", 32'(stall_cycles_o), 32'(stallsRef % (1 << CNT_W)));
    checkOutput("timeout_err", 32'(timeout_err_o), 32'(errRef));
  endtask

  initial begin
    rst_i = 1'b1;
    IFID_RS1addr_i = '0; IFID_RS2addr_i = '0; IDEX_RDaddr_i = '0;
    IDEX_MemRead_i = 1'b0; Branch_taken_i = 1'b0;
    EXMEM_MemRead_i = 1'b0; EXMEM_MemWrite_i = 1'b0; mem_ack_i = 1'b0;
    #12;
    checkOutput("rst_stall_cycles", 32'(stall_cycles_o), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err_o), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("rst_pc_write", 32'(PC_write_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Load-use, load to x0, branch, branch masked by load-use
    applyStimulus(5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 0);
    checkOutput("lu_count", 32'(stall_cycles_o), 32'd1);
    applyStimulus(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
    checkOutput("x0_count", 32'(stall_cycles_o), 32'd1);
    applyStimulus(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0);
    applyStimulus(5'd7, 5'd2, 5'd7, 1, 1, 0, 0, 0);
    checkOutput("br_lu_count", 32'(stall_cycles_o), 32'd2);

    // Miss acked three cycles after the request
    repeat (3) applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    checkOutput("miss_count", 32'(stall_cycles_o), 32'd5);

    // Load-use hazard during a store miss, presented again after the ack
    repeat (2) applyStimulus(5'd4, 5'd1, 5'd4, 1, 1, 0, 1, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    applyStimulus(5'd4, 5'd1, 5'd4, 1, 0, 0, 0, 0);
    checkOutput("hazard_after_ack", 32'(stall_cycles_o), 32'd8);

    // Timeout: request + 4 wait cycles, no ack; error stays set afterwards
    repeat (5) applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    checkOutput("timeout_set", 32'(timeout_err_o), 32'd1);
    checkOutput("timeout_count", 32'(stall_cycles_o), 32'd12);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    checkOutput("timeout_sticky", 32'(timeout_err_o), 32'd1);

    // Asynchronous reset while waiting on memory
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    applyStimulus(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("arst_count", 32'(stall_cycles_o), 32'd0);
    checkOutput("arst_err", 32'(timeout_err_o), 32'd0);
    checkOutput("arst_freeze_access", 32'(pipe_freeze_o), 32'd1);
    EXMEM_MemRead_i = 1'b0;
    #1;
    checkOutput("arst_freeze_idle", 32'(pipe_freeze_o), 32'd0);
    checkOutput("arst_req_idle", 32'(mem_req_o), 32'd0);
    age = -1; stallsRef = 0; errRef = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Random traffic; small register set makes load-use collisions common
    for (int i = 0; i < 800; i++) begin
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3),
                    ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 99) < 35));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
